// File: rtl/axi_lite_simple_master.sv
// Single-outstanding AXI4-Lite master: turns one command handshake into one AXI
// write or read transaction and returns the response through a valid/ready port.
module axi_lite_simple_master #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 32
) (
    input  logic                        M_AXI_ACLK,
    input  logic                        M_AXI_ARESET,

    input  logic                        CMD_VALID,
    output logic                        CMD_READY,
    input  logic                        CMD_WRITE,
    input  logic [AXI_ADDR_WIDTH-1:0]   CMD_ADDR,
    input  logic [AXI_DATA_WIDTH-1:0]   CMD_WDATA,
    input  logic [AXI_DATA_WIDTH/8-1:0] CMD_WSTRB,

    output logic                        RSP_VALID,
    input  logic                        RSP_READY,
    output logic [AXI_DATA_WIDTH-1:0]   RSP_RDATA,
    output logic [1:0]                  RSP_RESP,

    output logic [AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic [2:0]                  M_AXI_AWPROT,
    output logic                        M_AXI_AWVALID,
    input  logic                        M_AXI_AWREADY,

    output logic [AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                        M_AXI_WVALID,
    input  logic                        M_AXI_WREADY,

    input  logic [1:0]                  M_AXI_BRESP,
    input  logic                        M_AXI_BVALID,
    output logic                        M_AXI_BREADY,

    output logic [AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic [2:0]                  M_AXI_ARPROT,
    output logic                        M_AXI_ARVALID,
    input  logic                        M_AXI_ARREADY,

    input  logic [AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]                  M_AXI_RRESP,
    input  logic                        M_AXI_RVALID,
    output logic                        M_AXI_RREADY
);

    localparam int STRB_W = AXI_DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_RESP = 3'd2,
        RD_REQ  = 3'd3,
        RD_DATA = 3'd4,
        RSP     = 3'd5
    } state_t;

    state_t                      state_q,     state_d;
    logic                        cmd_ready_q, cmd_ready_d;
    logic [AXI_ADDR_WIDTH-1:0]   addr_q,      addr_d;
    logic [AXI_DATA_WIDTH-1:0]   wdata_q,     wdata_d;
    logic [STRB_W-1:0]           wstrb_q,     wstrb_d;
    logic                        awvalid_q,   awvalid_d;
    logic                        wvalid_q,    wvalid_d;
    logic                        aw_done_q,   aw_done_d;
    logic                        w_done_q,    w_done_d;
    logic                        bready_q,    bready_d;
    logic                        arvalid_q,   arvalid_d;
    logic                        rready_q,    rready_d;
    logic                        rsp_valid_q, rsp_valid_d;
    logic [AXI_DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic [1:0]                  rsp_resp_q,  rsp_resp_d;

    logic aw_hs;
    logic w_hs;

    assign aw_hs = awvalid_q && M_AXI_AWREADY;
    assign w_hs  = wvalid_q  && M_AXI_WREADY;

    always_comb begin
        state_d     = state_q;
        cmd_ready_d = cmd_ready_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        bready_d    = bready_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_resp_d  = rsp_resp_q;

        case (state_q)
            IDLE: begin
                // CMD_READY is itself registered, so the first IDLE cycle after
                // reset release only raises it; accepts start the cycle after.
                if (CMD_VALID && cmd_ready_q) begin
                    cmd_ready_d = 1'b0;
                    addr_d      = CMD_ADDR;
                    if (CMD_WRITE) begin
                        wdata_d   = CMD_WDATA;
                        wstrb_d   = CMD_WSTRB;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        aw_done_d = 1'b0;
                        w_done_d  = 1'b0;
                        state_d   = WR_REQ;
                    end else begin
                        arvalid_d = 1'b1;
                        state_d   = RD_REQ;
                    end
                end else begin
                    cmd_ready_d = 1'b1;
                end
            end

            WR_REQ: begin
                if (aw_hs) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (w_hs) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                // AW and W complete independently; move on once both are done.
                if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
                    bready_d = 1'b1;
                    state_d  = WR_RESP;
                end
            end

            WR_RESP: begin
                if (M_AXI_BVALID && bready_q) begin
                    bready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_resp_d  = M_AXI_BRESP;
                    state_d     = RSP;
                end
            end

            RD_REQ: begin
                if (arvalid_q && M_AXI_ARREADY) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RD_DATA;
                end
            end

            RD_DATA: begin
                if (M_AXI_RVALID && rready_q) begin
                    rready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = M_AXI_RDATA;
                    rsp_resp_d  = M_AXI_RRESP;
                    state_d     = RSP;
                end
            end

            RSP: begin
                if (RSP_READY) begin
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end

            default: begin
                state_d     = IDLE;
                cmd_ready_d = 1'b0;
                awvalid_d   = 1'b0;
                wvalid_d    = 1'b0;
                bready_d    = 1'b0;
                arvalid_d   = 1'b0;
                rready_d    = 1'b0;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
        if (M_AXI_ARESET) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= 2'b00;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_resp_q  <= rsp_resp_d;
        end
    end

    assign CMD_READY     = cmd_ready_q;
    assign RSP_VALID     = rsp_valid_q;
    assign RSP_RDATA     = rsp_rdata_q;
    assign RSP_RESP      = rsp_resp_q;

    assign M_AXI_AWADDR  = addr_q;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = wstrb_q;
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_BREADY  = bready_q;
    assign M_AXI_ARADDR  = addr_q;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_RREADY  = rready_q;

endmodule

// File: doc/axi_lite_simple_master.md
AXI_LITE_SIMPLE_MASTER -- requirements
Module: axi_lite_simple_master

Interface
REQ-001 AXI_ADDR_WIDTH, default 32: width of the command address and of M_AXI_AWADDR/M_AXI_ARADDR.
REQ-002 AXI_DATA_WIDTH, default 32, legal values 32 or 64: data width; strobe width is AXI_DATA_WIDTH/8.
REQ-003 M_AXI_ACLK  in  1  single clock; all logic on rising edge.
REQ-004 M_AXI_ARESET  in  1  reset, asynchronous and active-high.
REQ-005 CMD_VALID  in  1  command request.
REQ-006 CMD_READY  out  1  command accepted when high together with CMD_VALID.
REQ-007 CMD_WRITE  in  1  1 = write, 0 = read.
REQ-008 CMD_ADDR  in  AXI_ADDR_WIDTH  byte address.
REQ-009 CMD_WDATA  in  AXI_DATA_WIDTH  write data.
REQ-010 CMD_WSTRB  in  AXI_DATA_WIDTH/8  write byte strobes.
REQ-011 RSP_VALID  out  1  response available.
REQ-012 RSP_READY  in  1  response consumed when high together with RSP_VALID.
REQ-013 RSP_RDATA  out  AXI_DATA_WIDTH  read data; 0 for writes.
REQ-014 RSP_RESP  out  2  BRESP or RRESP of the completed transaction.
REQ-015 AW channel: M_AXI_AWADDR out AXI_ADDR_WIDTH, M_AXI_AWPROT out 3, M_AXI_AWVALID out 1, M_AXI_AWREADY in 1.
REQ-016 W channel: M_AXI_WDATA out AXI_DATA_WIDTH, M_AXI_WSTRB out AXI_DATA_WIDTH/8, M_AXI_WVALID out 1, M_AXI_WREADY in 1.
REQ-017 B channel: M_AXI_BRESP in 2, M_AXI_BVALID in 1, M_AXI_BREADY out 1.
REQ-018 AR channel: M_AXI_ARADDR out AXI_ADDR_WIDTH, M_AXI_ARPROT out 3, M_AXI_ARVALID out 1, M_AXI_ARREADY in 1.
REQ-019 R channel: M_AXI_RDATA in AXI_DATA_WIDTH, M_AXI_RRESP in 2, M_AXI_RVALID in 1, M_AXI_RREADY out 1.

Function
REQ-020 FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP; exactly one transaction is outstanding at a time.
REQ-021 CMD_READY SHALL be 1 only in IDLE; on accept, address, data and strobe are registered; next state is WR_REQ if CMD_WRITE=1, else RD_REQ.
REQ-022 WR_REQ: AWVALID and WVALID are asserted on the first cycle after accept; each drops on the cycle after its own handshake (VALID&&READY); the two handshakes may occur in either order or in the same cycle.
REQ-023 When both AW and W have handshaken, the FSM goes to WR_RESP; BREADY = 1 only in WR_RESP; on BVALID&&BREADY, BRESP is captured, RSP_RDATA is set to 0, and the FSM goes to RSP.
REQ-024 RD_REQ: ARVALID = 1 until ARREADY, then RD_DATA; RREADY = 1 only in RD_DATA; on RVALID&&RREADY, RDATA and RRESP are captured and the FSM goes to RSP.
REQ-025 Once asserted, no VALID output SHALL drop and no address, data or strobe output SHALL change before its handshake.
REQ-026 RSP: RSP_VALID = 1 and RSP_RDATA/RSP_RESP are held stable until RSP_READY; the FSM then returns to IDLE, so CMD_READY = 1 on the following cycle.
REQ-027 AWPROT and ARPROT SHALL be the constant 3'b000.
REQ-028 Minimum latency with a zero-wait slave: accept -> RSP_VALID = 3 cycles for writes and 3 cycles for reads.
REQ-029 CMD_VALID asserted outside IDLE SHALL be ignored, with no effect on the transaction in progress.
REQ-030 SLVERR or DECERR responses SHALL be passed unchanged through RSP_RESP; no retry is made.

Reset
REQ-031 While M_AXI_ARESET = 1, the state is IDLE and all outputs are 0 (CMD_READY = 0, RSP_VALID = 0, all AXI VALID/READY = 0, all address/data/strobe/prot = 0).
REQ-032 CMD_READY becomes 1 on the first clock edge after reset deasserts; a reset in any state aborts the transaction immediately and no response is produced.

Verification
REQ-033 Write 0xDEADBEEF to 0x0, WSTRB=0xF, zero-wait slave -> AW/W handshake in the same cycle; RSP_VALID 3 cycles after accept with RSP_RESP=00.
REQ-034 Slave delays AWREADY by 3 cycles and WREADY by 0 -> WVALID drops after 1 cycle; AWVALID and AWADDR are held stable; exactly one B handshake.
REQ-035 Write 4 words (0xDEADBEEF, 0xBAADF00D, 0xFEEDFACE, 0x0BADC0DE) to 0x0, 0x4, 0x8 and 0xC, then read them back -> RSP_RDATA matches each word in order.
REQ-036 Read where the slave returns RRESP=10 and RDATA=0x12345678, with RSP_READY held low for 5 cycles -> RSP_VALID, RSP_RDATA and RSP_RESP are stable until consumed.
REQ-037 Assert reset while in WR_RESP with BVALID low -> all outputs are 0 asynchronously; after release, a new read completes normally.
REQ-038 CMD_VALID held high continuously -> a new command is accepted only in IDLE; a protocol checker on the AXI bus reports no violations.
